// File: rtl/rv_core_pkg.sv
// Shared core definitions: data/address widths, writeback request record and
// requester indices used by the register-file writeback arbiter.
package rv_core_pkg;

    localparam int XLEN     = 32;
    localparam int RADDR_W  = 5;
    localparam int NUM_REGS = 32;

    typedef logic [RADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]    xlen_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        xlen_t     data;
    } wb_req_t;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    // True when the address names x0, which is hardwired to zero.
    function automatic logic is_x0(input reg_addr_t addr);
        return (addr == {RADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; the first valid
// requester is granted. The pointer moves past the winner on every grant and
// holds when nothing is requesting. Grants are forced low while n_rst is low.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [N-1:0] req_valid,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N-1:0]     grant_s;

    // Grant search from the pointer with wrap-around, plus next pointer value.
    always_comb begin
        int   idx;
        logic found;
        grant_s = {N{1'b0}};
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && req_valid[idx]) begin
                grant_s[idx] = 1'b1;
                found        = 1'b1;
                if (idx == N - 1) begin
                    ptr_d = {PTR_W{1'b0}};
                end else begin
                    ptr_d = PTR_W'(idx + 1);
                end
            end else begin
                found = found;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= {PTR_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = grant_s & {N{n_rst}};

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: owns the single RF write port, grants one
// writeback source per cycle round-robin, registers the write (1-cycle latency)
// and keeps a per-register scoreboard of in-flight writes for RAW stall
// detection. Optional forwarding of the retiring write is enabled by the
// RF_WB_FWD_EN macro.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rv_core_pkg::XLEN,
    parameter int RADDR_W = rv_core_pkg::RADDR_W
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*RADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       rsv_valid,
    input  logic [RADDR_W-1:0]         rsv_rd,
    input  logic [RADDR_W-1:0]         chk_rs1,
    input  logic [RADDR_W-1:0]         chk_rs2,
    output logic                       hazard,
`ifdef RF_WB_FWD_EN
    output logic                       fwd1_hit,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd_data,
`endif
    output logic                       RegWr,
    output logic [RADDR_W-1:0]         write_reg,
    output logic [XLEN-1:0]            write_data
);

    import rv_core_pkg::*;

    localparam int NREGS = 1 << RADDR_W;

    logic [NUM_REQ-1:0] grant_s;
    logic               hs_s;
    logic [RADDR_W-1:0] sel_rd_s;
    logic [XLEN-1:0]    sel_data_s;

    logic               reg_wr_q;
    logic               reg_wr_d;
    logic [RADDR_W-1:0] write_reg_q;
    logic [RADDR_W-1:0] write_reg_d;
    logic [XLEN-1:0]    write_data_q;
    logic [XLEN-1:0]    write_data_d;
    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;

    logic               rs1_term_s;
    logic               rs2_term_s;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .grant     (grant_s)
    );

    assign req_ready = grant_s;

    // Mux the granted requester's destination and data (grant is one-hot).
    always_comb begin
        hs_s       = 1'b0;
        sel_rd_s   = {RADDR_W{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i] && req_valid[i]) begin
                hs_s       = 1'b1;
                sel_rd_s   = req_rd[i*RADDR_W +: RADDR_W];
                sel_data_s = req_data[i*XLEN +: XLEN];
            end else begin
                hs_s = hs_s;
            end
        end
    end

    // Next write-port state: pulse for one cycle on a handshake to a non-x0
    // destination; address and data hold their last written values otherwise.
    always_comb begin
        reg_wr_d     = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (hs_s && (sel_rd_s != {RADDR_W{1'b0}})) begin
            reg_wr_d     = 1'b1;
            write_reg_d  = sel_rd_s;
            write_data_d = sel_data_s;
        end else begin
            reg_wr_d = 1'b0;
        end
    end

    // Write-port output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            reg_wr_q     <= 1'b0;
            write_reg_q  <= {RADDR_W{1'b0}};
            write_data_q <= {XLEN{1'b0}};
        end else begin
            reg_wr_q     <= reg_wr_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    // Scoreboard update: a reservation sets, the retiring RF write clears, and a
    // reservation of the same register in the same cycle wins over the clear.
    always_comb begin
        busy_d    = {NREGS{1'b0}};
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            busy_d[r] = (rsv_valid && (rsv_rd == RADDR_W'(r)))
                      | (busy_q[r] & ~(reg_wr_q && (write_reg_q == RADDR_W'(r))));
        end
    end

    // Scoreboard register; entry 0 is never set because x0 is never written.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef RF_WB_FWD_EN
    // Forwarding: the value retiring this cycle satisfies a matching source.
    always_comb begin
        fwd1_hit   = reg_wr_q & (write_reg_q == chk_rs1) & (chk_rs1 != {RADDR_W{1'b0}});
        fwd2_hit   = reg_wr_q & (write_reg_q == chk_rs2) & (chk_rs2 != {RADDR_W{1'b0}});
        fwd_data   = write_data_q;
        rs1_term_s = busy_q[chk_rs1] & ~fwd1_hit;
        rs2_term_s = busy_q[chk_rs2] & ~fwd2_hit;
    end
`else
    // Without forwarding a source stays hazardous until its RF write edge passes.
    always_comb begin
        rs1_term_s = busy_q[chk_rs1];
        rs2_term_s = busy_q[chk_rs2];
    end
`endif

    assign hazard     = rs1_term_s | rs2_term_s;
    assign RegWr      = reg_wr_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter: one table row per clock cycle
// (inputs plus expected outputs), followed by a hand-written reset-mid-burst
// sequence. Builds with or without RF_WB_FWD_EN.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        n_rst;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic        RegWr;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef RF_WB_FWD_EN
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    int cur_row = -1;

    rf_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .RADDR_W(5)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard     (hazard),
`ifdef RF_WB_FWD_EN
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd_data   (fwd_data),
`endif
        .RegWr      (RegWr),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] d0, d1, d2;
        logic        rsv_v;
        logic [4:0]  rsv_rd;
        logic [4:0]  rs1, rs2;
        logic [2:0]  e_ready;
        logic        e_wr;
        logic        chk_wd;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic        e_haz;
        logic        e_haz_fwd;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(
        input logic [2:0] valid, input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
        input logic rsv_v, input logic [4:0] rsv_r, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] e_ready, input logic e_wr, input logic chk_wd,
        input logic [4:0] e_wreg, input logic [31:0] e_wdata, input logic e_haz, input logic e_haz_fwd);
        vec_t v;
        v.valid = valid; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.rsv_v = rsv_v; v.rsv_rd = rsv_r; v.rs1 = rs1; v.rs2 = rs2;
        v.e_ready = e_ready; v.e_wr = e_wr; v.chk_wd = chk_wd;
        v.e_wreg = e_wreg; v.e_wdata = e_wdata; v.e_haz = e_haz; v.e_haz_fwd = e_haz_fwd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic drive_row(input vec_t v);
        req_valid = v.valid;
        req_rd    = {v.rd2, v.rd1, v.rd0};
        req_data  = {v.d2, v.d1, v.d0};
        rsv_valid = v.rsv_v;
        rsv_rd    = v.rsv_rd;
        chk_rs1   = v.rs1;
        chk_rs2   = v.rs2;
    endtask

    initial begin
        logic exp_haz;
        // Vectors assume the arbiter pointer, scoreboard and write port are at
        // their reset values when row 0 starts.
        tv[0]  = mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b001, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
        tv[1]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b000, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        // Pointer is 1: CSR alone wins, pointer wraps to 0.
        tv[2]  = mk(3'b100, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h10, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        // All three valid continuously: grants 0,1,2,0,1,2.
        tv[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b001, 1'b1, 1'b1, 5'd10, 32'h10, 1'b0, 1'b0);
        tv[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b010, 1'b1, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b0);
        tv[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b100, 1'b1, 1'b1, 5'd2, 32'h22222222, 1'b0, 1'b0);
        tv[6]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b001, 1'b1, 1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0);
        tv[7]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b010, 1'b1, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b0);
        tv[8]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b100, 1'b1, 1'b1, 5'd2, 32'h22222222, 1'b0, 1'b0);
        tv[9]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b000, 1'b1, 1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0);
        // Reserve x7, check it, LSU retires it.
        tv[10] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0);
        tv[11] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 1'b1);
        tv[12] = mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                    3'b010, 1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 1'b1);
        tv[13] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                    3'b000, 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
        tv[14] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        // CSR writes x0: handshake, no RF write, pointer advances to 0.
        tv[15] = mk(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b100, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        // ALU and CSR valid: pointer 0 picks ALU (pointer 2 would pick CSR); rsv x0 ignored.
        tv[16] = mk(3'b101, 5'd4, 5'd0, 5'd6, 32'h44, 32'h0, 32'h66, 1'b1, 5'd0, 5'd0, 5'd0,
                    3'b001, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tv[17] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                    3'b000, 1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
        // Reserve x9, CSR writes x9, re-reserve x9 on the retire edge: set wins.
        tv[18] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0,
                    3'b000, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
        tv[19] = mk(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99, 1'b0, 5'd0, 5'd0, 5'd9,
                    3'b100, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
        tv[20] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9,
                    3'b000, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        tv[21] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
                    3'b000, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);

        // Reset with all requesters valid.
        n_rst     = 1'b0;
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hC, 32'hB, 32'hA};
        rsv_valid = 1'b1;
        rsv_rd    = 5'd5;
        chk_rs1   = 5'd5;
        chk_rs2   = 5'd1;
        repeat (3) @(negedge clk);
        chk("reset_ready", {29'd0, req_ready}, 32'd0);
        chk("reset_regwr", {31'd0, RegWr}, 32'd0);
        chk("reset_hazard", {31'd0, hazard}, 32'd0);
        chk("reset_wreg", {27'd0, write_reg}, 32'd0);
        chk("reset_wdata", write_data, 32'd0);
        req_valid = 3'b000;
        rsv_valid = 1'b0;
        chk_rs1   = 5'd0;
        chk_rs2   = 5'd0;
        n_rst     = 1'b1;

        for (int r = 0; r < 22; r++) begin
            @(posedge clk);
            #1;
            cur_row = r;
            drive_row(tv[r]);
            @(negedge clk);
`ifdef RF_WB_FWD_EN
            exp_haz = tv[r].e_haz_fwd;
`else
            exp_haz = tv[r].e_haz;
`endif
            chk("req_ready", {29'd0, req_ready}, {29'd0, tv[r].e_ready});
            chk("RegWr", {31'd0, RegWr}, {31'd0, tv[r].e_wr});
            chk("hazard", {31'd0, hazard}, {31'd0, exp_haz});
            if (tv[r].chk_wd) begin
                chk("write_reg", {27'd0, write_reg}, {27'd0, tv[r].e_wreg});
                chk("write_data", write_data, tv[r].e_wdata);
            end else begin
                chk("x0_no_write", {31'd0, RegWr}, 32'd0);
            end
        end

        // Reset asserted mid-burst: x9 is still busy and a write is in flight.
        cur_row = 100;
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h33333333, 32'h22222222, 32'h11111111};
        rsv_valid = 1'b0;
        chk_rs1   = 5'd0;
        chk_rs2   = 5'd9;
        @(negedge clk);
        chk("burst_ready", {29'd0, req_ready}, 32'd1);
        chk("burst_hazard", {31'd0, hazard}, 32'd1);
        @(posedge clk);
        #1;
        chk("burst_regwr", {31'd0, RegWr}, 32'd1);
        chk("burst_wreg", {27'd0, write_reg}, 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("midrst_ready", {29'd0, req_ready}, 32'd0);
        chk("midrst_regwr", {31'd0, RegWr}, 32'd0);
        chk("midrst_wreg", {27'd0, write_reg}, 32'd0);
        chk("midrst_wdata", write_data, 32'd0);
        chk("midrst_hazard", {31'd0, hazard}, 32'd0);
        @(negedge clk);
        req_valid = 3'b000;
        n_rst     = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_hazard", {31'd0, hazard}, 32'd0);
        chk("postrst_regwr", {31'd0, RegWr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
